// File: rtl/string_fifo_avalon_master_if.sv
// ============================================================================
// Module      : string_fifo_avalon_master_if
// Description : Avalon-MM bus between the string FIFO initiator and the
//               accelerator's FIFO register slave (reg0 = data, reg2 = status).
//   av_chipselect  master->slave  high whenever av_read or av_write is high
//   av_address     master->slave  word address (0 = data, 2 = status)
//   av_write       master->slave  write strobe
//   av_writedata   master->slave  write data
//   av_read        master->slave  read strobe
//   av_readdata    slave->master  read data, READ_LATENCY cycles after accept
//   av_waitrequest slave->master  stall; master holds its outputs while high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface string_fifo_avalon_master_if;
  logic        av_chipselect;
  logic [2:0]  av_address;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_read;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_chipselect, av_address, av_write, av_writedata, av_read,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_chipselect, av_address, av_write, av_writedata, av_read,
    output av_readdata, av_waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/string_fifo_avalon_master.sv
// ============================================================================
// Module      : string_fifo_avalon_master
// Description : Avalon-MM initiator for the string accelerator's FIFO slave.
//               LOAD clears the slave FIFO and writes N streamed words to reg0.
//               UNLOAD reads the word count from reg2, then pops up to N words
//               from reg0 onto the output stream. One command at a time; each
//               ends with a one-cycle done pulse carrying word count and error.
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/ready/op/len     command channel (op 0 = LOAD, 1 = UNLOAD)
//   in_valid/ready/data        LOAD input stream
//   out_valid/ready/data       UNLOAD output stream
//   done, done_words, err      completion pulse and its status
//   bus                        Avalon-MM master port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module string_fifo_avalon_master #(
  parameter int MAX_WORDS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [3:0]  cmd_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        done,
  output logic [3:0]  done_words,
  output logic        err,
  string_fifo_avalon_master_if.master bus
);

  localparam logic [3:0] MAX_W    = 4'(MAX_WORDS);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_WAITIN, S_WR, S_STAT, S_STAT_WAIT,
    S_RD, S_RD_WAIT, S_PUSH, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  len_q;
  logic        clamp_err;
  logic        short_err;
  logic [3:0]  cnt;
  logic [3:0]  rd_n;
  logic [31:0] data_q;
  logic [1:0]  lat_cnt;

  logic [3:0]  len_acc;
  logic [3:0]  cnt_inc;
  logic [3:0]  avail;
  logic [3:0]  rd_n_new;
  logic        lat_done;

  assign len_acc  = (cmd_len > MAX_W) ? MAX_W : cmd_len;
  assign cnt_inc  = cnt + 4'd1;
  assign avail    = bus.av_readdata[3:0];
  assign rd_n_new = (avail < len_q) ? avail : len_q;
  // The read counter starts at 0 in the first cycle after acceptance, so the
  // data is present during the cycle in which it reaches READ_LATENCY-1.
  assign lat_done = (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n           = state;
    cmd_ready         = 1'b0;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    out_data          = '0;
    done              = 1'b0;
    done_words        = '0;
    err               = 1'b0;
    bus.av_read       = 1'b0;
    bus.av_write      = 1'b0;
    bus.av_address    = '0;
    bus.av_writedata  = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (len_acc == 4'd0) state_n = S_DONE;
          else if (cmd_op)     state_n = S_STAT;
          else                 state_n = S_CLR;
        end
      end
      S_CLR: begin
        bus.av_write   = 1'b1;
        bus.av_address = 3'd2;
        if (!bus.av_waitrequest) state_n = S_WAITIN;
      end
      S_WAITIN: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_WR;
      end
      S_WR: begin
        bus.av_write     = 1'b1;
        bus.av_address   = 3'd0;
        bus.av_writedata = data_q;
        if (!bus.av_waitrequest) state_n = (cnt_inc == len_q) ? S_DONE : S_WAITIN;
      end
      S_STAT: begin
        bus.av_read    = 1'b1;
        bus.av_address = 3'd2;
        if (!bus.av_waitrequest) state_n = S_STAT_WAIT;
      end
      S_STAT_WAIT: begin
        if (lat_done) state_n = (rd_n_new == 4'd0) ? S_DONE : S_RD;
      end
      S_RD: begin
        bus.av_read    = 1'b1;
        bus.av_address = 3'd0;
        if (!bus.av_waitrequest) state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_done) state_n = S_PUSH;
      end
      S_PUSH: begin
        // The next read is only issued once this word has been handed off.
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) state_n = (cnt_inc == rd_n) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done       = 1'b1;
        done_words = cnt;
        err        = clamp_err | short_err;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    bus.av_chipselect = bus.av_read | bus.av_write;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      clamp_err <= 1'b0;
      short_err <= 1'b0;
      cnt       <= '0;
      rd_n      <= '0;
      data_q    <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q     <= len_acc;
            clamp_err <= (cmd_len > MAX_W);
            short_err <= 1'b0;
            cnt       <= '0;
            rd_n      <= '0;
          end
        end
        S_WAITIN: if (in_valid) data_q <= in_data;
        S_WR:     if (!bus.av_waitrequest) cnt <= cnt_inc;
        S_STAT, S_RD: lat_cnt <= '0;
        S_STAT_WAIT: begin
          if (lat_done) begin
            rd_n      <= rd_n_new;
            short_err <= (avail < len_q);
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_RD_WAIT: begin
          if (lat_done) data_q  <= bus.av_readdata;
          else          lat_cnt <= lat_cnt + 2'd1;
        end
        S_PUSH: if (out_ready) cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_string_fifo_avalon_master.sv
// ============================================================================
// Module      : tb_string_fifo_avalon_master
// Description : Self-checking bench for string_fifo_avalon_master. Holds an
//               Avalon FIFO slave model, a queue-level reference of the slave
//               contents, and directed plus randomized LOAD/UNLOAD commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_string_fifo_avalon_master;
  localparam int MAXW = 8;
  localparam int RL   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [3:0]  cmd_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        done, err;
  logic [3:0]  done_words;

  string_fifo_avalon_master_if bus ();

  string_fifo_avalon_master #(.MAX_WORDS(MAXW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .done_words(done_words), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- Avalon FIFO slave model ----------------
  logic [31:0] slave_q[$];
  logic [35:0] log_q[$];   // {is_write, address, writedata}
  int          rd_pend = 0;
  logic [31:0] rd_val;
  logic [31:0] slv_v;

  always @(posedge clk) begin
    bus.av_readdata <= $urandom();
    if (rd_pend == 1) bus.av_readdata <= rd_val;
    if (rd_pend > 0) rd_pend = rd_pend - 1;
    if (reset && bus.av_write && !bus.av_waitrequest) begin
      log_q.push_back({1'b1, bus.av_address, bus.av_writedata});
      if (bus.av_address == 3'd2) slave_q.delete();
      else if (bus.av_address == 3'd0 && slave_q.size() < MAXW) slave_q.push_back(bus.av_writedata);
    end
    if (reset && bus.av_read && !bus.av_waitrequest) begin
      log_q.push_back({1'b0, bus.av_address, 32'h0});
      if (bus.av_address == 3'd2)  slv_v = 32'(slave_q.size());
      else if (slave_q.size() > 0) slv_v = slave_q.pop_front();
      else                         slv_v = 32'hDEAD_BEEF;
      if (RL == 1) bus.av_readdata <= slv_v;
      else begin rd_val = slv_v; rd_pend = RL - 1; end
    end
  end

  // ---------------- bus protocol monitor ----------------
  function automatic logic [37:0] bus_vec();
    return {bus.av_chipselect, bus.av_read, bus.av_write, bus.av_address, bus.av_writedata};
  endfunction

  logic        stall_snap = 1'b0;
  logic [37:0] snap_bus;
  logic        done_prev = 1'b0;

  always @(posedge clk) begin
    stall_snap <= reset && (bus.av_read || bus.av_write) && bus.av_waitrequest;
    snap_bus   <= bus_vec();
  end

  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (stall_snap) check("stall_hold", bus_vec(), snap_bus);
      check("rd_wr_excl", bus.av_read & bus.av_write, 0);
      check("chipselect", bus.av_chipselect, bus.av_read | bus.av_write);
      check("read_while_push", out_valid & bus.av_read, 0);
      if (done) check("done_one_cycle", done_prev, 0);
    end
    done_prev = done;
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] stim[$];
  int          stim_idx;
  logic [31:0] got[$];
  logic [31:0] ref_q[$];

  task automatic step(input bit rnd);
    @(negedge clk);
    bus.av_waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    out_ready          = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid           = (stim_idx < stim.size()) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    in_data            = (stim_idx < stim.size()) ? stim[stim_idx] : $urandom();
    #1;
    if (in_valid && in_ready)   stim_idx++;
    if (out_valid && out_ready) got.push_back(out_data);
  endtask

  task automatic run_cmd(input bit op, input logic [3:0] len, input bit rnd,
                         output logic [3:0] dw, output logic e, output int cyc);
    got.delete();
    log_q.delete();
    stim_idx = 0;
    step(rnd);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; dw = 'x; e = 1'bx;
    while (cyc < 400) begin
      step(rnd);
      cyc++;
      if (done) begin
        dw = done_words; e = err;
        check("cmd_ready_in_done", cmd_ready, 0);
        break;
      end
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  task automatic do_load(input logic [3:0] len, input bit rnd, input string tag);
    int n; logic [3:0] dw; logic e; int cyc;
    n = (len > MAXW) ? MAXW : int'(len);
    stim.delete();
    for (int i = 0; i < n + 2; i++) stim.push_back($urandom());
    run_cmd(1'b0, len, rnd, dw, e, cyc);
    check({tag, "_words"}, dw, n);
    check({tag, "_err"}, e, len > MAXW);
    check({tag, "_consumed"}, stim_idx, n);
    if (n == 0) begin
      check({tag, "_latency"}, cyc, 1);
      check({tag, "_nobus"}, log_q.size(), 0);
    end else begin
      ref_q.delete();
      for (int i = 0; i < n; i++) ref_q.push_back(stim[i]);
      check({tag, "_buslen"}, log_q.size(), n + 1);
      if (log_q.size() == n + 1) begin
        check({tag, "_clr"}, log_q[0], {1'b1, 3'd2, 32'd0});
        for (int i = 0; i < n; i++) check({tag, "_wr"}, log_q[i + 1], {1'b1, 3'd0, stim[i]});
      end
    end
    check({tag, "_slave_size"}, slave_q.size(), ref_q.size());
    if (slave_q.size() == ref_q.size())
      foreach (ref_q[i]) check({tag, "_slave_data"}, slave_q[i], ref_q[i]);
  endtask

  task automatic do_unload(input logic [3:0] len, input bit rnd, input string tag);
    int lq; int avail; int n; logic e_exp; logic [31:0] exp_w[$];
    logic [3:0] dw; logic e; int cyc;
    lq    = (len > MAXW) ? MAXW : int'(len);
    avail = ref_q.size();
    n     = (avail < lq) ? avail : lq;
    e_exp = (len > MAXW) || (avail < lq);
    exp_w.delete();
    for (int i = 0; i < n; i++) exp_w.push_back(ref_q.pop_front());
    stim.delete();
    run_cmd(1'b1, len, rnd, dw, e, cyc);
    check({tag, "_words"}, dw, n);
    check({tag, "_err"}, e, e_exp);
    check({tag, "_outcount"}, got.size(), n);
    if (got.size() == n) foreach (exp_w[i]) check({tag, "_outdata"}, got[i], exp_w[i]);
    if (lq == 0) check({tag, "_nobus"}, log_q.size(), 0);
    else begin
      check({tag, "_buslen"}, log_q.size(), n + 1);
      if (log_q.size() == n + 1) begin
        check({tag, "_stat"}, log_q[0], {1'b0, 3'd2, 32'd0});
        for (int i = 0; i < n; i++) check({tag, "_rd"}, log_q[i + 1], {1'b0, 3'd0, 32'd0});
      end
    end
    check({tag, "_slave_size"}, slave_q.size(), ref_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out"}, {out_valid, out_data}, 0);
    check({tag, "_done"}, {done, done_words, err}, 0);
    check({tag, "_bus"}, bus_vec(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; bus.av_waitrequest = 1'b0;
    stim_idx = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b1;

    // T1: LOAD 3 with fixed data and no stalls
    stim.delete();
    do_load(4'd3, 1'b0, "t1_pre");
    stim_idx = 0;
    got.delete(); log_q.delete();
    stim = '{32'h11111111, 32'h22222222, 32'h33333333};
    begin
      logic [3:0] dw; logic e; int cyc;
      run_cmd(1'b0, 4'd3, 1'b0, dw, e, cyc);
      check("t1_words", dw, 3);
      check("t1_err", e, 0);
      check("t1_buslen", log_q.size(), 4);
      if (log_q.size() == 4) begin
        check("t1_clr", log_q[0], {1'b1, 3'd2, 32'd0});
        check("t1_wr0", log_q[1], {1'b1, 3'd0, 32'h11111111});
        check("t1_wr1", log_q[2], {1'b1, 3'd0, 32'h22222222});
        check("t1_wr2", log_q[3], {1'b1, 3'd0, 32'h33333333});
      end
      ref_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    end

    // T2: UNLOAD 3 with 3 available
    do_unload(4'd3, 1'b0, "t2");
    // T3: UNLOAD 5 with only 2 available
    do_load(4'd2, 1'b0, "t3_load");
    do_unload(4'd5, 1'b0, "t3");
    // T4: clamped LOAD, zero-length LOAD, clamped UNLOAD
    do_load(4'd12, 1'b0, "t4_clamp");
    do_load(4'd0, 1'b0, "t4_zero");
    do_unload(4'd10, 1'b0, "t4_unload");
    do_unload(4'd0, 1'b0, "t4_unload_zero");

    // T5: random stalls and back-pressure
    for (int k = 0; k < 20; k++) begin
      do_load(4'($urandom_range(0, 10)), 1'b1, "t5_load");
      do_unload(4'($urandom_range(0, 10)), 1'b1, "t5_unload");
    end

    // T6: reset while a data write is on the bus
    stim = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hC3C3C3C3, 32'h3C3C3C3C};
    stim_idx = 0;
    step(1'b0);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_len = 4'd4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0);
      if (bus.av_write && bus.av_address == 3'd0) found = 1'b1;
    end
    check("t6_wr_seen", found, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("t6_reset");
    repeat (3) begin
      @(negedge clk);
      #1 check("t6_no_done", done, 0);
    end
    reset = 1'b1;
    ref_q.delete();
    check("t6_slave_cleared", slave_q.size(), 0);
    stim.delete();
    do_load(4'd3, 1'b0, "t6_load");
    do_unload(4'd3, 1'b1, "t6_unload");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
